// File: rtl/aes_canright_pkg.sv
// Shared Canright tower-field arithmetic (normal basis) and basis-change constants
// for the AES forward and inverse S-boxes.
package aes_canright_pkg;

  localparam logic [7:0] AFFINE_C = 8'h63;

  // Row for input bit i lives at [8*i +: 8]; the top byte is the bit-7 row.
  localparam logic [63:0] S2X_ROWS = 64'h8C79_05EB_1204_5153;
  localparam logic [63:0] X2A_ROWS = 64'h6478_6E8C_6829_DE60;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } isb_state_e;

  // GF(2^2), normal basis (W^2, W)
  function automatic logic [1:0] g4_mul(input logic [1:0] x, input logic [1:0] y);
    logic e;
    e = (x[1] ^ x[0]) & (y[1] ^ y[0]);
    return {(x[1] & y[1]) ^ e, (x[0] & y[0]) ^ e};
  endfunction

  function automatic logic [1:0] g4_scl_n(input logic [1:0] x);
    return {x[0], x[1] ^ x[0]};
  endfunction

  function automatic logic [1:0] g4_scl_n2(input logic [1:0] x);
    return {x[1] ^ x[0], x[1]};
  endfunction

  // Squaring and inversion coincide in GF(2^2).
  function automatic logic [1:0] g4_sq(input logic [1:0] x);
    return {x[0], x[1]};
  endfunction

  // GF(2^4), normal basis (alpha^8, alpha^2)
  function automatic logic [3:0] g16_mul(input logic [3:0] x, input logic [3:0] y);
    logic [1:0] e;
    e = g4_scl_n(g4_mul(x[3:2] ^ x[1:0], y[3:2] ^ y[1:0]));
    return {g4_mul(x[3:2], y[3:2]) ^ e, g4_mul(x[1:0], y[1:0]) ^ e};
  endfunction

  function automatic logic [3:0] g16_sq_scl(input logic [3:0] x);
    return {g4_sq(x[3:2] ^ x[1:0]), g4_scl_n2(g4_sq(x[1:0]))};
  endfunction

  function automatic logic [3:0] g16_inv(input logic [3:0] x);
    logic [1:0] c;
    logic [1:0] d;
    logic [1:0] e;
    c = g4_scl_n(g4_sq(x[3:2] ^ x[1:0]));
    d = g4_mul(x[3:2], x[1:0]);
    e = g4_sq(c ^ d);
    return {g4_mul(e, x[1:0]), g4_mul(e, x[3:2])};
  endfunction

  // GF(2^8), normal basis (d^16, d); 0 maps to 0.
  function automatic logic [7:0] g256_inv(input logic [7:0] x);
    logic [3:0] c;
    logic [3:0] d;
    logic [3:0] e;
    c = g16_sq_scl(x[7:4] ^ x[3:0]);
    d = g16_mul(x[7:4], x[3:0]);
    e = g16_inv(c ^ d);
    return {g16_mul(e, x[3:0]), g16_mul(e, x[7:4])};
  endfunction

  function automatic logic [7:0] change_basis(input logic [7:0] x, input logic [63:0] rows);
    logic [7:0] y;
    y = '0;
    for (int i = 0; i < 8; i++) begin
      if (x[i]) y ^= rows[8*i +: 8];
    end
    return y;
  endfunction

endpackage

// File: rtl/canright_inv_sbox.sv
// AES inverse S-box built on the shared tower-field inverter; PIPE=1 registers
// the GF(2^8) inverse before the output basis change.
module canright_inv_sbox
  import aes_canright_pkg::*;
#(
  parameter int PIPE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  logic [7:0] inv_d;
  logic [7:0] inv_q;

  assign inv_d = g256_inv(change_basis(din ^ AFFINE_C, S2X_ROWS));

  generate
    if (PIPE != 0) begin : g_pipe
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) inv_q <= '0;
        else        inv_q <= inv_d;
      end
    end else begin : g_comb
      assign inv_q = inv_d;
    end
  endgenerate

  assign dout = change_basis(inv_q, X2A_ROWS);

endmodule

// File: rtl/inv_subbytes_serial.sv
// Serial InvSubBytes: one shared inverse S-box walks the state one byte per
// cycle, rewriting the work register in place, then holds the result for handoff.
module inv_subbytes_serial
  import aes_canright_pkg::*;
#(
  parameter int NBYTES = 16,
  parameter int PIPE   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] out_data,
  output logic                busy
);

  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  isb_state_e          state_reg;
  isb_state_e          state_next;
  logic [CW-1:0]       ctr_reg;
  logic [8*NBYTES-1:0] work_reg;
  logic                in_ready_reg;
  logic [7:0]          sbox_in;
  logic [7:0]          sbox_out;
  logic                wr_en;
  logic [CW-1:0]       wr_idx;
  logic                accept;

  assign accept  = (state_reg == ST_IDLE) && in_valid && in_ready_reg;
  assign sbox_in = work_reg[8*int'(ctr_reg) +: 8];

  canright_inv_sbox #(
    .PIPE(PIPE)
  ) u_sbox (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (sbox_in),
    .dout (sbox_out)
  );

  always_comb begin
    state_next = state_reg;
    wr_en      = 1'b0;
    wr_idx     = ctr_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) state_next = ST_RUN;
      end
      ST_RUN: begin
        // With the pipeline register the sbox result belongs to the previous byte.
        if (PIPE != 0) begin
          wr_en  = (ctr_reg != '0);
          wr_idx = ctr_reg - CW'(1);
        end else begin
          wr_en  = 1'b1;
        end
        if (ctr_reg == LAST) state_next = (PIPE != 0) ? ST_DRAIN : ST_DONE;
      end
      ST_DRAIN: begin
        wr_en      = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      ctr_reg      <= '0;
      work_reg     <= '0;
      in_ready_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next == ST_IDLE);
      if (state_reg == ST_IDLE) begin
        ctr_reg <= '0;
        if (accept) work_reg <= in_data;
      end else begin
        if (state_reg == ST_RUN && ctr_reg != LAST) ctr_reg <= ctr_reg + CW'(1);
        if (wr_en) work_reg[8*int'(wr_idx) +: 8] <= sbox_out;
      end
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = (state_reg == ST_DONE);
  assign out_data  = work_reg;
  assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_inv_subbytes_serial.sv
// Scoreboard bench: PIPE=1 and PIPE=0 engines share stimulus; expectations come
// from a polynomial-basis GF(2^8) model of the forward S-box, inverted into a table.
module tb_inv_subbytes_serial;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] in_data;
  logic         out_ready;
  logic         rdy1, ov1, busy1;
  logic         rdy0, ov0, busy0;
  logic [127:0] od1, od0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;

  logic [7:0]   inv_tab [256];
  logic [127:0] exp_q1 [$];
  logic [127:0] exp_q0 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inv_subbytes_serial #(.NBYTES(16), .PIPE(1)) dut_p1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .busy(busy1)
  );

  inv_subbytes_serial #(.NBYTES(16), .PIPE(0)) dut_p0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .busy(busy0)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end else begin
      $display("ok   %s: %h (cycle %0d)", tag, got, cyc);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, x);
    return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] model_state(input logic [127:0] d);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = inv_tab[d[8*k +: 8]];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] data, input logic [127:0] exp);
    int guard;
    guard = 0;
    while (!(rdy1 && rdy0) && guard < 100) begin
      tick();
      guard++;
    end
    if (!(rdy1 && rdy0)) begin
      check_eq("send_timeout", {126'd0, rdy1, rdy0}, 128'd3);
      return;
    end
    in_valid = 1'b1;
    in_data  = data;
    exp_q1.push_back(exp);
    exp_q0.push_back(exp);
    acc_cyc = cyc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((exp_q1.size() != 0 || exp_q0.size() != 0) && guard < 200) begin
      tick();
      guard++;
    end
    check_eq("drain", 128'(exp_q1.size() + exp_q0.size()), 128'd0);
  endtask

  task automatic wait_both_valid();
    int guard;
    guard = 0;
    while (!(ov1 && ov0) && guard < 100) begin
      tick();
      guard++;
    end
    check_eq("valid_wait", {126'd0, ov1, ov0}, 128'd3);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    exp_q1.delete();
    exp_q0.delete();
    check_eq("rst_out_valid", {127'd0, ov1}, 128'd0);
    check_eq("rst_busy", {127'd0, busy1}, 128'd0);
    check_eq("rst_in_ready", {127'd0, rdy1}, 128'd0);
    check_eq("rst_out_data", od1, 128'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check_eq("rdy_before_edge", {127'd0, rdy1}, 128'd0);
    tick();
    check_eq("rdy_after_edge", {127'd0, rdy1}, 128'd1);
  endtask

  initial begin
    logic         prev1;
    logic         prev0;
    logic [127:0] snap;
    logic [127:0] d;

    for (int x = 0; x < 256; x++) inv_tab[fwd_sbox(8'(x))] = 8'(x);
    prev1     = 1'b0;
    prev0     = 1'b0;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          prev1 = 1'b0;
          prev0 = 1'b0;
        end else begin
          if (ov1 && !prev1) check_eq("lat_p1", 128'(cyc - acc_cyc - 1), 128'd17);
          if (ov0 && !prev0) check_eq("lat_p0", 128'(cyc - acc_cyc - 1), 128'd16);
          if (ov1 && out_ready) begin
            if (exp_q1.size() == 0) check_eq("extra_p1", od1, 128'hx);
            else check_eq("data_p1", od1, exp_q1.pop_front());
          end
          if (ov0 && out_ready) begin
            if (exp_q0.size() == 0) check_eq("extra_p0", od0, 128'hx);
            else check_eq("data_p0", od0, exp_q0.pop_front());
          end
          prev1 = ov1;
          prev0 = ov0;
        end
      end
    join_none

    #3;
    apply_reset();

    // all 0x63 bytes map to zero
    send({16{8'h63}}, 128'd0);
    wait_drain();

    // byte k = k
    for (int k = 0; k < 16; k++) d[8*k +: 8] = 8'(k);
    send(d, 128'hFBD7F3819EA340BF38A53630D56A0952);
    wait_drain();

    // single values in the last byte
    send({8'hFF, {15{8'h63}}}, {8'h7D, 120'd0});
    send({8'h16, {15{8'h63}}}, {8'hFF, 120'd0});
    send({8'h7C, {15{8'h63}}}, {8'h01, 120'd0});
    send({8'h00, {15{8'h63}}}, {8'h52, 120'd0});
    wait_drain();

    // backpressure: output held, new input ignored
    out_ready = 1'b0;
    d = {$urandom, $urandom, $urandom, $urandom};
    send(d, model_state(d));
    wait_both_valid();
    snap     = od1;
    in_valid = 1'b1;
    in_data  = ~d;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (i % 10 == 9) begin
        check_eq("hold_data", od1, snap);
        check_eq("hold_valid", {126'd0, ov1, ov0}, 128'd3);
        check_eq("hold_ready", {126'd0, rdy1, rdy0}, 128'd0);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    d = {$urandom, $urandom, $urandom, $urandom};
    send(d, model_state(d));
    wait_drain();

    // every byte value, sixteen per state
    for (int s = 0; s < 16; s++) begin
      for (int k = 0; k < 16; k++) d[8*k +: 8] = 8'(16 * s + k);
      send(d, model_state(d));
    end
    wait_drain();

    // reset in the middle of a run
    send({16{8'hA5}}, model_state({16{8'hA5}}));
    for (int i = 0; i < 5; i++) tick();
    check_eq("busy_mid_run", {127'd0, busy1}, 128'd1);
    apply_reset();

    // reset while holding a finished result
    out_ready = 1'b0;
    send({16{8'h3C}}, model_state({16{8'h3C}}));
    wait_both_valid();
    apply_reset();
    out_ready = 1'b1;

    send({16{8'h63}}, 128'd0);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
